// File: rtl/test_wave_gen.sv
// Multi-channel synthetic test-signal source: ramp/square/triangle/constant patterns,
// one sample per channel per prescaler strobe, indexed over a fixed record length.
module test_wave_gen #(
  parameter int DATA_W  = 12,
  parameter int CH      = 2,
  parameter int REC_LEN = 15360,
  parameter int IDX_W   = 14,
  parameter int DIV_W   = 8
) (
  input  logic                 CS,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic [2*CH-1:0]      MODE,
  input  logic [DATA_W*CH-1:0] STEP,
  input  logic [DIV_W-1:0]     DIV,
  output logic [DATA_W*CH-1:0] DATA_OUT,
  output logic                 VALID,
  output logic [IDX_W-1:0]     INDEX,
  output logic                 FRAME_START
);

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REC_LEN - 1);

  logic [DIV_W-1:0]     presc;
  logic                 tick;
  logic [IDX_W-1:0]     nidx;
  logic                 rec_end;
  logic [DATA_W-1:0]    acc [CH];
  logic [DATA_W*CH-1:0] shaped;

  // Map one accumulator value to an output sample for the selected pattern.
  function automatic logic [DATA_W-1:0] shape(input logic [1:0]        mode,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] level);
    logic [DATA_W-1:0] dbl;
    dbl = {a[DATA_W-2:0], 1'b0};
    case (mode)
      MODE_RAMP:   return a;
      MODE_SQUARE: return a[DATA_W-1] ? '1 : '0;
      MODE_TRI:    return a[DATA_W-1] ? ~dbl : dbl;
      default:     return level;
    endcase
  endfunction

  // ">=" rather than "==" so that lowering DIV below the current count still fires.
  assign tick    = EN && (presc >= DIV);
  assign rec_end = (nidx == LAST_IDX);

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge CS or negedge RST_N) begin
    if (!RST_N) begin
      presc <= '0;
    end else if (!EN || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // NOTE: a default before the loop keeps this block purely combinational (no latch).
  always_comb begin
    shaped = '0;
    for (int k = 0; k < CH; k++) begin
      shaped[k*DATA_W +: DATA_W] = shape(MODE[2*k +: 2], acc[k], STEP[k*DATA_W +: DATA_W]);
    end
  end

  // NOTE: the accumulator array is tiny and must restart every record from 0,
  // so it is reset explicitly like ordinary flops.
  always_ff @(posedge CS or negedge RST_N) begin
    if (!RST_N) begin
      DATA_OUT    <= '0;
      VALID       <= 1'b0;
      INDEX       <= '0;
      FRAME_START <= 1'b0;
      nidx        <= '0;
      for (int k = 0; k < CH; k++) acc[k] <= '0;
    end else begin
      VALID       <= tick;
      FRAME_START <= tick && (nidx == '0);
      if (tick) begin
        INDEX    <= nidx;
        DATA_OUT <= shaped;
        nidx     <= rec_end ? '0 : nidx + 1'b1;
        for (int k = 0; k < CH; k++) begin
          acc[k] <= rec_end ? '0 : acc[k] + STEP[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_test_wave_gen.sv
// Scoreboard bench for test_wave_gen: arithmetic reference model pushes expected
// samples, a negedge monitor pops and compares whenever VALID is seen.
module tb_test_wave_gen;

  localparam int DW  = 12;
  localparam int CH  = 2;
  localparam int REC = 15360;

  typedef struct {
    logic [13:0]    idx;
    logic           fs;
    logic [DW*CH-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [2*CH-1:0]  mode;
  logic [DW*CH-1:0] step;
  logic [7:0]       div;
  logic [DW*CH-1:0] data_out;
  logic             valid;
  logic [13:0]      index;
  logic             frame_start;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];
  logic [13:0]      last_idx  = '0;
  logic [DW*CH-1:0] last_data = '0;
  int n_valid   = 0;
  int frame_cnt = 0;

  test_wave_gen dut (
    .CS          (clk),
    .RST_N       (rst_n),
    .EN          (en),
    .MODE        (mode),
    .STEP        (step),
    .DIV         (div),
    .DATA_OUT    (data_out),
    .VALID       (valid),
    .INDEX       (index),
    .FRAME_START (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pattern functions written from the waveform definitions, in plain integers.
  function automatic int wave(input int m, input int a, input int lvl);
    case (m)
      0:       return a;
      1:       return (a >= 2048) ? 4095 : 0;
      2:       return (a < 2048) ? 2 * a : 4095 - 2 * (a - 2048);
      default: return lvl;
    endcase
  endfunction

  // Reference model: counts consecutive enabled cycles; a strobe happens once
  // more than DIV of them have elapsed. Samples within a record use acc = running sum.
  initial begin
    int   run;
    int   m_idx;
    int   m_acc [CH];
    exp_t e;
    run = 0;
    m_idx = 0;
    foreach (m_acc[k]) m_acc[k] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        run = 0;
        m_idx = 0;
        foreach (m_acc[k]) m_acc[k] = 0;
        exp_q.delete();
      end else if (!en) begin
        run = 0;
      end else begin
        run++;
        if (run > int'(div)) begin
          run = 0;
          e.idx = 14'(m_idx);
          e.fs  = (m_idx == 0);
          e.data = '0;
          for (int k = 0; k < CH; k++) begin
            e.data[k*DW +: DW] = 12'(wave(int'(mode[2*k +: 2]), m_acc[k], int'(step[k*DW +: DW])));
          end
          exp_q.push_back(e);
          for (int k = 0; k < CH; k++) begin
            m_acc[k] = (m_idx == REC - 1) ? 0 : (m_acc[k] + int'(step[k*DW +: DW])) % 4096;
          end
          m_idx = (m_idx + 1) % REC;
        end
      end
    end
  end

  // Monitor: pops on VALID, otherwise checks that outputs hold.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_idx  = '0;
        last_data = '0;
      end else if (valid) begin
        n_valid++;
        if (frame_start) frame_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("index", 32'(index), 32'(e.idx));
          check("frame_start", 32'(frame_start), 32'(e.fs));
          check("data_out", 32'(data_out), 32'(e.data));
          last_idx  = e.idx;
          last_data = e.data;
        end
      end else begin
        check("hold_index", 32'(index), 32'(last_idx));
        check("hold_data", 32'(data_out), 32'(last_data));
        check("idle_frame_start", 32'(frame_start), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input int bound, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (valid) ok = 1'b1;
    end
    if (!ok) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 32'(data_out), 32'd0);
    check({tag, "_index"}, 32'(index), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_frame"}, 32'(frame_start), 32'd0);
  endtask

  // Assert reset away from any clock edge and confirm outputs clear asynchronously.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int          cyc;
    bit          ok;
    int          cnt;
    logic [13:0] idx_before;
    logic [11:0] tri_tab [8];

    tri_tab = '{12'd0, 12'd1024, 12'd2048, 12'd3072, 12'd4095, 12'd3071, 12'd2047, 12'd1023};

    rst_n = 1'b0;
    en    = 1'b0;
    mode  = '0;
    step  = {12'd1, 12'd1};
    div   = 8'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Ramp over a full record plus wrap.
    en = 1'b1;
    cnt = 0;
    while (n_valid < REC + 2 && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    check("record_wrap_reached", 32'(n_valid >= REC + 2), 32'd1);
    check("frame_count", 32'(frame_cnt), 32'd2);

    // Divided rate: one strobe in four.
    div = 8'd3;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid) cnt++;
    end
    check("div3_rate", 32'(cnt), 32'd10);

    // Pause and resume.
    en = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid) cnt++;
    end
    check("paused_no_valid", 32'(cnt), 32'd0);
    idx_before = last_idx;
    en = 1'b1;
    wait_valid(20, cyc, ok);
    check("resume_latency", 32'(cyc), 32'd4);
    check("resume_index", 32'(index), 32'(idx_before + 14'd1));

    // Square and triangle from a fresh record.
    en   = 1'b0;
    div  = 8'd0;
    mode = {2'd2, 2'd1};
    step = {12'd512, 12'd256};
    do_reset("rst_mid");
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_valid(5, cyc, ok);
      check("square_ch0", 32'(data_out[11:0]), (i < 8) ? 32'd0 : 32'd4095);
      check("triangle_ch1", 32'(data_out[23:12]), 32'(tri_tab[i % 8]));
    end

    // Constant level on ch0, ramp on ch1.
    mode = {2'd0, 2'd3};
    step = {12'd3, 12'hABC};
    for (int i = 0; i < 20; i++) begin
      wait_valid(5, cyc, ok);
      check("const_ch0", 32'(data_out[11:0]), 32'hABC);
    end

    // Asynchronous reset mid-record.
    mode = '0;
    step = {12'd1, 12'd1};
    cnt = 0;
    while (last_idx < 14'd500 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    check("reached_idx_500", 32'(last_idx >= 14'd500), 32'd1);
    do_reset("rst_async");
    wait_valid(5, cyc, ok);
    check("post_reset_index", 32'(index), 32'd0);
    check("post_reset_frame", 32'(frame_start), 32'd1);
    check("post_reset_data", 32'(data_out), 32'd0);

    // Randomised mode/step/div/enable traffic, checked by the scoreboard.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = 4'($urandom);
      if ($urandom_range(0, 7) == 0) step = 24'($urandom);
      if ($urandom_range(0, 15) == 0) div = 8'($urandom_range(0, 3));
    end

    en = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
